// File: rtl/clk_div_sched_if.sv
// Control and status bundle for the programmable clock-enable scheduler.
// The master drives the run request and the divisor offers. The slave reports
// back the handshake, the error pulse, the divisor in force and the tick/div_clk outputs.
interface clk_div_sched_if #(
  parameter int CNT_W = 8
);
  logic             enable;
  logic             cfg_valid;
  logic [CNT_W-1:0] cfg_div;
  logic             cfg_ready;
  logic             cfg_err;
  logic [CNT_W-1:0] cur_div;
  logic             tick;
  logic             div_clk;
  logic             busy;

  modport master (
    output enable, cfg_valid, cfg_div,
    input  cfg_ready, cfg_err, cur_div, tick, div_clk, busy
  );

  modport slave (
    input  enable, cfg_valid, cfg_div,
    output cfg_ready, cfg_err, cur_div, tick, div_clk, busy
  );
endinterface

// File: rtl/clk_div_sched.sv
// Programmable clock-enable scheduler: one-cycle tick plus ~50% div_clk at clk/N.
// Latency: tick rises one cycle after enable is first sampled; all outputs but cfg_ready registered.
// Backpressure: cfg_ready drops while a divisor change waits for the period boundary.
module clk_div_sched #(
  parameter int CNT_W       = 8,
  parameter int DEFAULT_DIV = 2
) (
  input  logic              clk,
  input  logic              nrst,
  clk_div_sched_if.slave    bus
);

  localparam logic [CNT_W-1:0] RST_DIV = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  typedef enum logic [1:0] {
    OFF    = 2'd0,
    RUN    = 2'd1,
    SWITCH = 2'd2
  } state_t;

  state_t           state, nxt_state;
  logic [CNT_W-1:0] cnt, nxt_cnt;
  logic [CNT_W-1:0] cur_div, nxt_div;
  logic [CNT_W-1:0] pend_div, nxt_pend;
  logic [CNT_W:0]   nxt_half;
  logic             cfg_ready;
  logic             accept;
  logic             cfg_zero;
  logic             take_div;
  logic             boundary;
  logic             tick_q, div_clk_q, busy_q, cfg_err_q;

  // Offers are only refused while a change is already queued.
  assign cfg_ready = (state != SWITCH);
  assign accept    = bus.cfg_valid && cfg_ready;
  assign cfg_zero  = (bus.cfg_div == '0);
  assign take_div  = accept && !cfg_zero;
  // Last cycle of the current period; cur_div >= 1 so the subtract never wraps.
  assign boundary  = (state != OFF) && (cnt == (cur_div - ONE));

  // Next-state decode: divisor swaps and stops are confined to period boundaries.
  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    nxt_div   = cur_div;
    nxt_pend  = pend_div;
    case (state)
      OFF: begin
        nxt_cnt = '0;
        if (take_div) nxt_div = bus.cfg_div;
        if (bus.enable) nxt_state = RUN;
      end
      RUN, SWITCH: begin
        nxt_cnt = boundary ? '0 : cnt + ONE;
        if (state == SWITCH && boundary) begin
          nxt_div   = pend_div;
          nxt_state = RUN;
        end
        if (state == RUN && take_div) begin
          nxt_pend  = bus.cfg_div;
          nxt_state = SWITCH;
        end
        // Stopping: no later boundary exists, so a divisor accepted on this
        // very cycle is applied directly instead of being left pending.
        if (boundary && !bus.enable) begin
          nxt_state = OFF;
          nxt_cnt   = '0;
          if (state == RUN && take_div) nxt_div = bus.cfg_div;
        end
      end
      default: begin
        nxt_state = OFF;
        nxt_cnt   = '0;
      end
    endcase
  end

  // High-phase length is ceil(N/2); one extra bit keeps N = 2^CNT_W-1 from wrapping.
  assign nxt_half = ({1'b0, nxt_div} + {{CNT_W{1'b0}}, 1'b1}) >> 1;

  // State, counter and registered outputs, all derived from the next-cycle values.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state     <= OFF;
      cnt       <= '0;
      cur_div   <= RST_DIV;
      pend_div  <= '0;
      tick_q    <= 1'b0;
      div_clk_q <= 1'b0;
      busy_q    <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state     <= nxt_state;
      cnt       <= nxt_cnt;
      cur_div   <= nxt_div;
      pend_div  <= nxt_pend;
      tick_q    <= (nxt_state != OFF) && (nxt_cnt == '0);
      div_clk_q <= (nxt_state != OFF) && ({1'b0, nxt_cnt} < nxt_half);
      busy_q    <= (nxt_state != OFF);
      cfg_err_q <= accept && cfg_zero;
    end
  end

  assign bus.cfg_ready = cfg_ready;
  assign bus.cfg_err   = cfg_err_q;
  assign bus.cur_div   = cur_div;
  assign bus.tick      = tick_q;
  assign bus.div_clk   = div_clk_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_clk_div_sched.sv
// Directed bench for clk_div_sched: reset, divide-by-3, deferred switch,
// zero-divisor error, stop/no-gap restart, mid-switch reset, N=1 and N=255.
module tb_clk_div_sched;

  logic clk;
  logic nrst;
  int   n_tests;
  int   n_fail;

  clk_div_sched_if #(.CNT_W(8)) bus ();

  clk_div_sched #(.CNT_W(8), .DEFAULT_DIV(2)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drop enable and wait (bounded) for the block to reach OFF.
  task automatic go_idle();
    int waited;
    bus.enable    = 1'b0;
    bus.cfg_valid = 1'b0;
    waited = 0;
    while (bus.busy !== 1'b0 && waited < 600) begin
      step();
      waited++;
    end
    n_tests++;
    if (bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_timeout busy=%b want 0", bus.busy);
    end
  endtask

  // Offer a divisor for exactly one cycle.
  task automatic offer(input logic [7:0] v);
    bus.cfg_valid = 1'b1;
    bus.cfg_div   = v;
    step();
    bus.cfg_valid = 1'b0;
  endtask

  task automatic test_reset();
    nrst = 1'b1;
    #3 nrst = 1'b0;
    #4;
    n_tests++;
    if ({bus.tick, bus.div_clk, bus.busy, bus.cfg_err, bus.cfg_ready} !== 5'b00001) begin
      n_fail++;
      $display("FAIL reset_flags tick/div/busy/err/rdy=%b want 00001",
               {bus.tick, bus.div_clk, bus.busy, bus.cfg_err, bus.cfg_ready});
    end
    n_tests++;
    if (bus.cur_div !== 8'd2) begin
      n_fail++;
      $display("FAIL reset_cur_div got %0d want 2", bus.cur_div);
    end
    step();
    nrst = 1'b1;
    step();
  endtask

  task automatic test_div3();
    offer(8'd3);
    n_tests++;
    if (bus.cur_div !== 8'd3) begin
      n_fail++;
      $display("FAIL div3_cur_div got %0d want 3", bus.cur_div);
    end
    bus.enable = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      step();
      n_tests++;
      if (bus.tick !== (((k - 1) % 3) == 0)) begin
        n_fail++;
        $display("FAIL div3_tick k=%0d got %b want %b", k, bus.tick, (((k - 1) % 3) == 0));
      end
      n_tests++;
      if (bus.div_clk !== (((k - 1) % 3) < 2)) begin
        n_fail++;
        $display("FAIL div3_div_clk k=%0d got %b want %b", k, bus.div_clk, (((k - 1) % 3) < 2));
      end
    end
    go_idle();
  endtask

  task automatic test_switch();
    logic e_tick, e_rdy, e_dc;
    logic [7:0] e_div;
    offer(8'd4);
    bus.enable = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      e_tick = (k == 1) || (k == 5) || (k == 7) || (k == 9);
      e_rdy  = !((k == 3) || (k == 4));
      e_div  = (k < 5) ? 8'd4 : 8'd2;
      e_dc   = (k < 5) ? (k <= 2) : (((k - 5) % 2) == 0);
      n_tests++;
      if (bus.tick !== e_tick) begin
        n_fail++;
        $display("FAIL switch_tick k=%0d got %b want %b", k, bus.tick, e_tick);
      end
      n_tests++;
      if (bus.cfg_ready !== e_rdy) begin
        n_fail++;
        $display("FAIL switch_ready k=%0d got %b want %b", k, bus.cfg_ready, e_rdy);
      end
      n_tests++;
      if (bus.cur_div !== e_div) begin
        n_fail++;
        $display("FAIL switch_cur_div k=%0d got %0d want %0d", k, bus.cur_div, e_div);
      end
      n_tests++;
      if (bus.div_clk !== e_dc) begin
        n_fail++;
        $display("FAIL switch_div_clk k=%0d got %b want %b", k, bus.div_clk, e_dc);
      end
      if (k == 2) begin
        bus.cfg_valid = 1'b1;
        bus.cfg_div   = 8'd2;
      end
      if (k == 3) bus.cfg_valid = 1'b0;
    end
    go_idle();
  endtask

  task automatic test_cfg_zero();
    offer(8'd5);
    bus.enable = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      n_tests++;
      if (bus.cfg_err !== (k == 3)) begin
        n_fail++;
        $display("FAIL zero_err k=%0d got %b want %b", k, bus.cfg_err, (k == 3));
      end
      n_tests++;
      if (bus.cfg_ready !== 1'b1 || bus.cur_div !== 8'd5) begin
        n_fail++;
        $display("FAIL zero_state k=%0d rdy=%b div=%0d want 1/5", k, bus.cfg_ready, bus.cur_div);
      end
      n_tests++;
      if (bus.tick !== (((k - 1) % 5) == 0)) begin
        n_fail++;
        $display("FAIL zero_tick k=%0d got %b want %b", k, bus.tick, (((k - 1) % 5) == 0));
      end
      if (k == 2) begin
        bus.cfg_valid = 1'b1;
        bus.cfg_div   = 8'd0;
      end
      if (k == 3) bus.cfg_valid = 1'b0;
    end
    go_idle();
  endtask

  task automatic test_stop();
    offer(8'd5);
    bus.enable = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      n_tests++;
      if (bus.busy !== (k <= 5)) begin
        n_fail++;
        $display("FAIL stop_busy k=%0d got %b want %b", k, bus.busy, (k <= 5));
      end
      n_tests++;
      if (bus.tick !== (k == 1) || bus.div_clk !== (k <= 3)) begin
        n_fail++;
        $display("FAIL stop_outs k=%0d tick=%b dc=%b want %b/%b", k, bus.tick, bus.div_clk, (k == 1), (k <= 3));
      end
      if (k == 2) bus.enable = 1'b0;
    end
    // Re-raise before the boundary: the period train must not break.
    bus.enable = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      n_tests++;
      if (bus.busy !== 1'b1 || bus.tick !== (((k - 1) % 5) == 0)) begin
        n_fail++;
        $display("FAIL nogap k=%0d busy=%b tick=%b want 1/%b", k, bus.busy, bus.tick, (((k - 1) % 5) == 0));
      end
      if (k == 2) bus.enable = 1'b0;
      if (k == 4) bus.enable = 1'b1;
    end
    go_idle();
  endtask

  task automatic test_reset_switch();
    offer(8'd4);
    bus.enable = 1'b1;
    step();
    step();
    bus.cfg_valid = 1'b1;
    bus.cfg_div   = 8'd7;
    step();
    bus.cfg_valid = 1'b0;
    n_tests++;
    if (bus.cfg_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL rsw_pending ready=%b want 0", bus.cfg_ready);
    end
    bus.enable = 1'b0;
    nrst = 1'b0;
    #1;
    n_tests++;
    if ({bus.tick, bus.div_clk, bus.busy, bus.cfg_ready} !== 4'b0001 || bus.cur_div !== 8'd2) begin
      n_fail++;
      $display("FAIL rsw_async tick/dc/busy/rdy=%b div=%0d want 0001/2",
               {bus.tick, bus.div_clk, bus.busy, bus.cfg_ready}, bus.cur_div);
    end
    #1 nrst = 1'b1;
    bus.enable = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step();
      n_tests++;
      if (bus.tick !== (k % 2 == 1) || bus.div_clk !== (k % 2 == 1) || bus.cur_div !== 8'd2) begin
        n_fail++;
        $display("FAIL rsw_period2 k=%0d tick=%b dc=%b div=%0d want %b/%b/2",
                 k, bus.tick, bus.div_clk, bus.cur_div, (k % 2 == 1), (k % 2 == 1));
      end
    end
    go_idle();
  endtask

  task automatic test_extremes();
    offer(8'd1);
    bus.enable = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step();
      n_tests++;
      if (bus.tick !== 1'b1 || bus.div_clk !== 1'b1) begin
        n_fail++;
        $display("FAIL n1 k=%0d tick=%b dc=%b want 1/1", k, bus.tick, bus.div_clk);
      end
    end
    go_idle();
    offer(8'd255);
    bus.enable = 1'b1;
    for (int k = 1; k <= 520; k++) begin
      step();
      n_tests++;
      if (bus.tick !== (((k - 1) % 255) == 0) || bus.div_clk !== (((k - 1) % 255) < 128)) begin
        n_fail++;
        $display("FAIL n255 k=%0d tick=%b dc=%b want %b/%b", k, bus.tick, bus.div_clk,
                 (((k - 1) % 255) == 0), (((k - 1) % 255) < 128));
      end
    end
    go_idle();
  endtask

  initial begin
    n_tests       = 0;
    n_fail        = 0;
    bus.enable    = 1'b0;
    bus.cfg_valid = 1'b0;
    bus.cfg_div   = 8'd0;
    test_reset();
    test_div3();
    test_switch();
    test_cfg_zero();
    test_stop();
    test_reset_switch();
    test_extremes();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
